fir_interpolator: RTL

// Transmit-side counterpart of the receive FIR path: polyphase interpolating FIR for audio playback.
// - Each accepted input sample produces L filtered output samples (zero-stuff by L, then lowpass).
// - Sits between the sample source and the DAC/PWM output stage.
// - Input side: valid/ready. Output side: valid/ready with backpressure.

---
 rtl/fir_interpolator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fir_interpolator.sv
// Polyphase interpolating FIR: each accepted sample yields L filtered outputs, one MAC per cycle.
// Coefficients come from the COEFFS parameter, h[i] at bits [i*COEF_WIDTH +: COEF_WIDTH].
module fir_interpolator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned L          = 4,
    parameter int unsigned TAPS       = 32,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned FRAC       = 14,
    // Default prototype: triangular kernel of length 2L-1, i.e. linear interpolation.
    parameter logic [TAPS*COEF_WIDTH-1:0] COEFFS = {
        {25{16'h0000}},
        16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h3000, 16'h2000, 16'h1000
    }
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic signed [WIDTH-1:0] audio_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] audio_out,
    output logic                    valid_out,
    input  logic                    ready_in
);

    localparam int unsigned N     = TAPS / L;
    localparam int unsigned ACC_W = WIDTH + COEF_WIDTH + $clog2(N);
    localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned TW    = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(1 << (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {StIdle, StMac, StRound, StEmit} state_e;

    state_e                         state_q, state_d;
    logic        [PW-1:0]           p_q, p_d;
    logic        [KW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [WIDTH-1:0]        dl_q [N];
    logic signed [WIDTH-1:0]        dl_d [N];
    logic signed [WIDTH-1:0]        audio_q, audio_d;
    logic                           valid_q, valid_d;

    logic signed [COEF_WIDTH-1:0]   h [TAPS];
    logic        [TW-1:0]           tap_idx;
    logic signed [COEF_WIDTH-1:0]   coef;
    logic signed [WIDTH+COEF_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        biased;
    logic signed [ACC_W-1:0]        shifted;
    logic signed [WIDTH-1:0]        sat_val;

    for (genvar i = 0; i < TAPS; i++) begin : g_coef
        assign h[i] = COEFFS[i*COEF_WIDTH +: COEF_WIDTH];
    end

    assign tap_idx = TW'(k_q * L + p_q);
    assign coef    = h[tap_idx];
    assign prod    = coef * dl_q[k_q];

    // Round half-up, then arithmetic shift and clamp to the output range.
    assign biased  = acc_q + HALF;
    assign shifted = biased >>> FRAC;

    always_comb begin
        sat_val = shifted[WIDTH-1:0];
        if (shifted > SAT_HI) begin
            sat_val = SAT_HI[WIDTH-1:0];
        end else if (shifted < SAT_LO) begin
            sat_val = SAT_LO[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        acc_d   = acc_q;
        audio_d = audio_q;
        valid_d = valid_q;
        for (int i = 0; i < N; i++) begin
            dl_d[i] = dl_q[i];
        end

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    for (int i = N - 1; i > 0; i--) begin
                        dl_d[i] = dl_q[i-1];
                    end
                    dl_d[0] = audio_in;
                    p_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + ACC_W'(prod);
                if (k_q == KW'(N - 1)) begin
                    state_d = StRound;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StRound: begin
                audio_d = sat_val;
                valid_d = 1'b1;
                state_d = StEmit;
            end
            StEmit: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    if (p_q == PW'(L - 1)) begin
                        p_d     = '0;
                        state_d = StIdle;
                    end else begin
                        p_d     = p_q + 1'b1;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = StMac;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            p_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
            for (int i = 0; i < N; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

    assign ready_out = (state_q == StIdle);
    assign audio_out = audio_q;
    assign valid_out = valid_q;

endmodule
